// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds hex value and digit-valid mask from a scanned active-low seven-segment bus
//   clk, rst_n          : clock, asynchronous active-low reset
//   segment             : active-low {dp,g,f,e,d,c,b,a} pattern
//   segsel              : active-low one-hot digit select
//   dout, dout_vld      : recovered nibbles and per-digit valid of the last complete frame
//   frame_vld           : one-cycle strobe when dout/dout_vld update
//   glyph_err           : one-cycle pulse for an undecodable non-blank capture
//   scan_lost           : level, no accepted capture for TIMEOUT cycles
module seg_scan_capture #(
   parameter int SEG_NUM    = 8,
   parameter int STABLE_CNT = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             segment,
   input  logic [SEG_NUM-1:0]     segsel,
   output logic [4*SEG_NUM-1:0]   dout,
   output logic [SEG_NUM-1:0]     dout_vld,
   output logic                   frame_vld,
   output logic                   glyph_err,
   output logic                   scan_lost
);
   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [7:0]           r_seg, r_seg_p;
   logic [SEG_NUM-1:0]   r_sel, r_sel_p;
   logic [SW-1:0]        r_stb;
   logic [TW-1:0]        r_to;
   logic [4*SEG_NUM-1:0] r_shd, w_shd_nx, r_dout;
   logic [SEG_NUM-1:0]   r_shv, w_shv_nx, r_seen, w_seen_nx, r_dvld, w_oh;
   logic [3:0]           w_nib;
   logic                 w_gv, w_blank, w_same, w_acc, r_frame, r_gerr, r_lost;
   assign w_oh      = ~r_sel;
   assign w_same    = {r_seg, r_sel} == {r_seg_p, r_sel_p};
   // fires once per dwell: the edge on which the counter steps to STABLE_CNT-1
   assign w_acc     = w_same && (r_stb == SW'(STABLE_CNT - 2)) && (w_oh != '0) &&
                      ((w_oh & (w_oh - SEG_NUM'(1))) == '0);
   assign w_blank   = r_seg[6:0] == 7'h7F;
   assign w_seen_nx = r_seen | w_oh;
   always_comb begin
      w_gv  = 1'b1;
      w_nib = 4'h0;
      case (r_seg[6:0])
         7'h40: w_nib = 4'h0;
         7'h79: w_nib = 4'h1;
         7'h24: w_nib = 4'h2;
         7'h30: w_nib = 4'h3;
         7'h19: w_nib = 4'h4;
         7'h12: w_nib = 4'h5;
         7'h02: w_nib = 4'h6;
         7'h78: w_nib = 4'h7;
         7'h00: w_nib = 4'h8;
         7'h10: w_nib = 4'h9;
         7'h08: w_nib = 4'hA;
         7'h03: w_nib = 4'hB;
         7'h46: w_nib = 4'hC;
         7'h21: w_nib = 4'hD;
         7'h06: w_nib = 4'hE;
         7'h0E: w_nib = 4'hF;
         default: w_gv = 1'b0;
      endcase
   end
   always_comb begin
      for (int i = 0; i < SEG_NUM; i++) begin
         w_shd_nx[4*i+:4] = w_oh[i] ? w_nib : r_shd[4*i+:4];
         w_shv_nx[i]      = w_oh[i] ? w_gv : r_shv[i];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= '1;
         r_sel   <= '1;
         r_seg_p <= '1;
         r_sel_p <= '1;
         r_stb   <= '0;
         r_to    <= '0;
         r_shd   <= '0;
         r_shv   <= '0;
         r_seen  <= '0;
         r_dout  <= '0;
         r_dvld  <= '0;
         r_frame <= 1'b0;
         r_gerr  <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_seg   <= segment;
         r_sel   <= segsel;
         r_seg_p <= r_seg;
         r_sel_p <= r_sel;
         r_stb   <= !w_same ? '0 : (r_stb == SW'(STABLE_CNT)) ? r_stb : r_stb + 1'b1;
         r_frame <= 1'b0;
         r_gerr  <= w_acc && !w_gv && !w_blank;
         if (w_acc) begin
            r_to   <= '0;
            r_lost <= 1'b0;
            r_shd  <= w_shd_nx;
            r_shv  <= w_shv_nx;
            // the completing capture publishes straight from the updated shadow
            if (&w_seen_nx) begin
               r_seen  <= '0;
               r_dout  <= w_shd_nx;
               r_dvld  <= w_shv_nx;
               r_frame <= 1'b1;
            end else begin
               r_seen <= w_seen_nx;
            end
         end else begin
            if (r_to != TW'(TIMEOUT)) r_to <= r_to + 1'b1;
            if (r_to == TW'(TIMEOUT - 1)) begin
               r_lost <= 1'b1;
               r_seen <= '0;
            end
         end
      end
   end
   assign dout      = r_dout;
   assign dout_vld  = r_dvld;
   assign frame_vld = r_frame;
   assign glyph_err = r_gerr;
   assign scan_lost = r_lost;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed bench for seg_scan_capture (SEG_NUM=8, STABLE_CNT=3, TIMEOUT=50)
module tb_seg_scan_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  segment = 8'hFF;
   logic [7:0]  segsel = 8'hFF;
   logic [31:0] dout;
   logic [7:0]  dout_vld;
   logic        frame_vld, glyph_err, scan_lost;
   int          vectors = 0, miscompares = 0, fv_cnt = 0, ge_cnt = 0, fb, gb;
   localparam logic [6:0] G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   seg_scan_capture #(.SEG_NUM(8), .STABLE_CNT(3), .TIMEOUT(50)) dut (
      .clk(clk), .rst_n(rst_n), .segment(segment), .segsel(segsel), .dout(dout),
      .dout_vld(dout_vld), .frame_vld(frame_vld), .glyph_err(glyph_err), .scan_lost(scan_lost)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (frame_vld) fv_cnt++;
      if (glyph_err) ge_cnt++;
   end
   function automatic logic [7:0] pat(input logic [3:0] n);
      return {1'b1, G[n]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic dig(input int d, input logic [7:0] s);
      segment = s;
      segsel  = ~(8'h1 << d);
      repeat (4) @(negedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      segment = 8'hFF;
      segsel  = 8'hFF;
      repeat (n) @(negedge clk);
      #1;
   endtask
   task automatic frame(input logic [31:0] v);
      for (int i = 0; i < 8; i++) dig(i, pat(v[4*i+:4]));
   endtask
   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_dout", dout, 32'h0);
      chk("rst_dout_vld", {24'h0, dout_vld}, 32'h0);
      chk("rst_frame_vld", {31'h0, frame_vld}, 32'h0);
      chk("rst_glyph_err", {31'h0, glyph_err}, 32'h0);
      chk("rst_scan_lost", {31'h0, scan_lost}, 32'h0);
      rst_n = 1'b1;
      idle(3);
      fb = fv_cnt;
      gb = ge_cnt;
      for (int i = 0; i < 7; i++) dig(i, pat(4'(8 - i)));
      chk("hex_no_early_frame", fv_cnt - fb, 0);
      dig(7, pat(4'h1));
      chk("hex_frame_cnt", fv_cnt - fb, 1);
      chk("hex_frame_vld_now", {31'h0, frame_vld}, 32'h1);
      chk("hex_dout", dout, 32'h12345678);
      chk("hex_dout_vld", {24'h0, dout_vld}, 32'hFF);
      idle(1);
      chk("hex_strobe_one_cycle", {31'h0, frame_vld}, 32'h0);
      chk("hex_no_glyph_err", ge_cnt - gb, 0);
      fb = fv_cnt;
      gb = ge_cnt;
      dig(0, pat(4'h8));
      dig(1, pat(4'h5));
      for (int i = 2; i < 8; i++) dig(i, 8'hFF);
      chk("blank_frame_cnt", fv_cnt - fb, 1);
      chk("blank_dout", dout, 32'h00000058);
      chk("blank_dout_vld", {24'h0, dout_vld}, 32'h03);
      chk("blank_no_glyph_err", ge_cnt - gb, 0);
      fb = fv_cnt;
      gb = ge_cnt;
      dig(0, pat(4'h8));
      dig(1, pat(4'h7));
      dig(2, pat(4'h6));
      segment = 8'hA4;
      segsel  = ~(8'h1 << 3);
      repeat (2) @(negedge clk);
      #1;
      dig(3, pat(4'h5));
      dig(4, pat(4'h4));
      dig(5, 8'h7E);
      chk("bad_glyph_pulse", ge_cnt - gb, 1);
      dig(6, pat(4'h2));
      dig(7, pat(4'h1));
      chk("glitch_frame_cnt", fv_cnt - fb, 1);
      chk("glitch_dout", dout, 32'h12045678);
      chk("glitch_dout_vld", {24'h0, dout_vld}, 32'hDF);
      chk("bad_glyph_single", ge_cnt - gb, 1);
      for (int i = 0; i < 7; i++) dig(i, pat(4'(8 - i)));
      dig(7, 8'h7E);
      chk("last_err_glyph_err", {31'h0, glyph_err}, 32'h1);
      chk("last_err_frame_vld", {31'h0, frame_vld}, 32'h1);
      chk("last_err_dout", dout, 32'h02345678);
      chk("last_err_dout_vld", {24'h0, dout_vld}, 32'h7F);
      fb = fv_cnt;
      dig(0, pat(4'h0));
      dig(1, pat(4'hF));
      dig(2, pat(4'hE));
      dig(3, pat(4'hD));
      segment = pat(4'h1);
      segsel  = 8'hFC;
      repeat (10) @(negedge clk);
      #1;
      chk("badsel_no_frame", fv_cnt - fb, 0);
      dig(4, pat(4'hC));
      dig(5, pat(4'hB));
      dig(6, pat(4'hA));
      dig(7, pat(4'h9));
      chk("badsel_frame_cnt", fv_cnt - fb, 1);
      chk("badsel_dout", dout, 32'h9ABCDEF0);
      chk("badsel_dout_vld", {24'h0, dout_vld}, 32'hFF);
      frame(32'h12345678);
      chk("pre_lost_dout", dout, 32'h12345678);
      dig(0, pat(4'h6));
      dig(1, pat(4'h3));
      dig(2, pat(4'h2));
      dig(3, pat(4'h9));
      idle(49);
      chk("lost_not_yet", {31'h0, scan_lost}, 32'h0);
      idle(1);
      chk("lost_set", {31'h0, scan_lost}, 32'h1);
      chk("lost_dout_hold", dout, 32'h12345678);
      fb = fv_cnt;
      dig(4, pat(4'h4));
      chk("lost_cleared", {31'h0, scan_lost}, 32'h0);
      dig(5, pat(4'h1));
      dig(6, pat(4'h8));
      dig(7, pat(4'h5));
      chk("lost_seen_cleared", fv_cnt - fb, 0);
      dig(0, pat(4'h6));
      dig(1, pat(4'h3));
      dig(2, pat(4'h2));
      dig(3, pat(4'h9));
      chk("lost_new_frame_cnt", fv_cnt - fb, 1);
      chk("lost_new_dout", dout, 32'h58149236);
      for (int i = 0; i < 5; i++) dig(i, pat(4'(8 - i)));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", dout, 32'h0);
      chk("mid_rst_dout_vld", {24'h0, dout_vld}, 32'h0);
      chk("mid_rst_frame_vld", {31'h0, frame_vld}, 32'h0);
      chk("mid_rst_scan_lost", {31'h0, scan_lost}, 32'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      fb = fv_cnt;
      dig(5, pat(4'h3));
      dig(6, pat(4'h2));
      dig(7, pat(4'h1));
      for (int i = 0; i < 4; i++) dig(i, pat(4'(8 - i)));
      chk("post_rst_partial_dropped", fv_cnt - fb, 0);
      dig(4, pat(4'h4));
      chk("post_rst_frame_cnt", fv_cnt - fb, 1);
      chk("post_rst_dout", dout, 32'h12345678);
      chk("post_rst_dout_vld", {24'h0, dout_vld}, 32'hFF);
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
